// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, CON bit indices and FSM encodings for uart_periph.
// Frame length and parity states follow the UART_PARITY_EN build option.
package uart_pkg;

  localparam logic [31:0] OFF_TXD = 32'h0;
  localparam logic [31:0] OFF_RXD = 32'h4;
  localparam logic [31:0] OFF_CON = 32'h8;

  localparam int CON_TX_IE   = 0;
  localparam int CON_RX_IE   = 1;
  localparam int CON_TX_DONE = 2;
  localparam int CON_RX_RDY  = 3;
  localparam int CON_TX_BUSY = 4;
  localparam int CON_OVR     = 5;
  localparam int CON_PAR_ERR = 7;

  localparam int TICKS_PER_BIT = 16;

`ifdef UART_PARITY_EN
  localparam int BITS_PER_FRAME = 11;
`else
  localparam int BITS_PER_FRAME = 10;
`endif

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_STOP   = 3'd3
`ifdef UART_PARITY_EN
    ,TX_PARITY = 3'd4
`endif
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_STOP   = 3'd3
`ifdef UART_PARITY_EN
    ,RX_PARITY = 3'd4
`endif
  } rx_state_e;

`ifdef UART_PARITY_EN
  localparam tx_state_e TX_AFTER_DATA = TX_PARITY;
  localparam rx_state_e RX_AFTER_DATA = RX_PARITY;
`else
  localparam tx_state_e TX_AFTER_DATA = TX_STOP;
  localparam rx_state_e RX_AFTER_DATA = RX_STOP;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider producing a one-cycle 16x oversample tick.
// Shared by the tx and rx paths of uart_periph.
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART (TXD/RXD/CON) with level irq.
// Define UART_PARITY_EN for an even parity bit on tx and parity check on rx.
module uart_periph
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ  = 100_000_000,
  parameter int          BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tx,
  input  logic        rx
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam logic [31:0] TXD_A = BASE_ADDR + OFF_TXD;
  localparam logic [31:0] RXD_A = BASE_ADDR + OFF_RXD;
  localparam logic [31:0] CON_A = BASE_ADDR + OFF_CON;
  localparam logic [3:0]  TLAST = 4'(TICKS_PER_BIT - 1);
  localparam logic [3:0]  TMID  = 4'(TICKS_PER_BIT / 2 - 1);

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  logic sel_txd, sel_rxd, sel_con;
  logic wr_txd, wr_con, rd_rxd, rd_con;
  logic unused_ok;

  assign sel_txd = (addr[31:2] == TXD_A[31:2]);
  assign sel_rxd = (addr[31:2] == RXD_A[31:2]);
  assign sel_con = (addr[31:2] == CON_A[31:2]);
  assign wr_txd  = wr & sel_txd;
  assign wr_con  = wr & sel_con;
  assign rd_rxd  = rd & sel_rxd;
  assign rd_con  = rd & sel_con;
  assign unused_ok = ^{addr[1:0], wdata[31:8]};

  logic       tx_ie, rx_ie, tx_done, rx_rdy, overrun, par_err;
  logic [7:0] rxd;

  tx_state_e  tx_st, tx_st_d;
  logic [7:0] tx_byte, tx_byte_d;
  logic [3:0] tx_tcnt, tx_tcnt_d;
  logic [3:0] tx_idx, tx_idx_d;
  logic       tx_busy, tx_busy_d;
  logic       tx_fin, tx_d, tx_bit_end;

  assign tx_bit_end = tick && (tx_tcnt == TLAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st   <= TX_IDLE;
      tx_byte <= '0;
      tx_tcnt <= '0;
      tx_idx  <= '0;
      tx_busy <= 1'b0;
      tx      <= 1'b1;
    end else begin
      tx_st   <= tx_st_d;
      tx_byte <= tx_byte_d;
      tx_tcnt <= tx_tcnt_d;
      tx_idx  <= tx_idx_d;
      tx_busy <= tx_busy_d;
      tx      <= tx_d;
    end
  end

  // tx_idx counts frame slots: 0 start, 1..8 data, then parity/stop
  always_comb begin
    tx_st_d   = tx_st;
    tx_byte_d = tx_byte;
    tx_tcnt_d = tx_tcnt;
    tx_idx_d  = tx_idx;
    tx_busy_d = tx_busy;
    tx_fin    = 1'b0;
    tx_d      = 1'b1;
    if (tx_st != TX_IDLE && tick) tx_tcnt_d = tx_tcnt + 4'd1;
    if (tx_bit_end) tx_idx_d = tx_idx + 4'd1;
    unique case (tx_st)
      TX_IDLE: begin
        tx_tcnt_d = '0;
        tx_idx_d  = '0;
        if (wr_txd && !tx_busy) begin
          tx_byte_d = wdata[7:0];
          tx_busy_d = 1'b1;
        end else if (tx_busy && tick) begin
          tx_st_d = TX_START;
        end
      end
      TX_START:
        if (tx_bit_end) tx_st_d = TX_DATA;
      TX_DATA:
        if (tx_bit_end && tx_idx == 4'd8) tx_st_d = TX_AFTER_DATA;
`ifdef UART_PARITY_EN
      TX_PARITY:
        if (tx_bit_end) tx_st_d = TX_STOP;
`endif
      TX_STOP:
        if (tx_bit_end && tx_idx == 4'(BITS_PER_FRAME - 1)) begin
          tx_st_d   = TX_IDLE;
          tx_busy_d = 1'b0;
          tx_fin    = 1'b1;
        end
      default: tx_st_d = TX_IDLE;
    endcase
    unique case (tx_st_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_byte_d[3'(tx_idx_d - 4'd1)];
`ifdef UART_PARITY_EN
      TX_PARITY: tx_d = ^tx_byte_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  logic       rx_s1, rx_s2, rx_s3;
  rx_state_e  rx_st, rx_st_d;
  logic [3:0] rx_tcnt, rx_tcnt_d;
  logic [2:0] rx_cnt, rx_cnt_d;
  logic [7:0] rx_sh, rx_sh_d;
  logic       rx_perr, rx_perr_d;
  logic       rx_fin, par_set, rx_sample;

  assign rx_sample = tick && (rx_tcnt == TLAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_s3   <= 1'b1;
      rx_st   <= RX_IDLE;
      rx_tcnt <= '0;
      rx_cnt  <= '0;
      rx_sh   <= '0;
      rx_perr <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      rx_st   <= rx_st_d;
      rx_tcnt <= rx_tcnt_d;
      rx_cnt  <= rx_cnt_d;
      rx_sh   <= rx_sh_d;
      rx_perr <= rx_perr_d;
    end
  end

  // after the mid-start check, every 16th tick lands on a bit centre
  always_comb begin
    rx_st_d   = rx_st;
    rx_tcnt_d = rx_tcnt;
    rx_cnt_d  = rx_cnt;
    rx_sh_d   = rx_sh;
    rx_perr_d = rx_perr;
    rx_fin    = 1'b0;
    par_set   = 1'b0;
    if (rx_st != RX_IDLE && tick) rx_tcnt_d = rx_tcnt + 4'd1;
    unique case (rx_st)
      RX_IDLE: begin
        rx_tcnt_d = '0;
        rx_cnt_d  = '0;
        rx_perr_d = 1'b0;
        if (rx_s3 && !rx_s2) rx_st_d = RX_START;
      end
      RX_START:
        if (tick && rx_tcnt == TMID) begin
          rx_tcnt_d = '0;
          rx_st_d   = rx_s2 ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (rx_sample) begin
          rx_sh_d  = {rx_s2, rx_sh[7:1]};
          rx_cnt_d = rx_cnt + 3'd1;
          if (rx_cnt == 3'd7) rx_st_d = RX_AFTER_DATA;
        end
`ifdef UART_PARITY_EN
      RX_PARITY:
        if (rx_sample) begin
          rx_perr_d = (^rx_sh) ^ rx_s2;
          rx_st_d   = RX_STOP;
        end
`endif
      RX_STOP:
        if (rx_sample) begin
          rx_st_d = RX_IDLE;
          if (rx_s2) begin
            par_set = rx_perr;
            rx_fin  = !rx_perr;
          end
        end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // set terms are OR-ed last so a completing event beats a read-clear
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ie   <= 1'b0;
      rx_ie   <= 1'b0;
      tx_done <= 1'b0;
      rx_rdy  <= 1'b0;
      overrun <= 1'b0;
      par_err <= 1'b0;
      rxd     <= '0;
      irq     <= 1'b0;
    end else begin
      if (wr_con) begin
        tx_ie <= wdata[CON_TX_IE];
        rx_ie <= wdata[CON_RX_IE];
      end
      tx_done <= tx_fin | (tx_done & ~rd_con);
      rx_rdy  <= rx_fin | (rx_rdy & ~rd_rxd);
      overrun <= (rx_fin & rx_rdy) | (overrun & ~rd_con);
      par_err <= par_set | (par_err & ~rd_con);
      if (rx_fin) rxd <= rx_sh;
      irq <= (tx_ie & tx_done) | (rx_ie & rx_rdy);
    end
  end

  logic [31:0] con_v;

  always_comb begin
    con_v = '0;
    con_v[CON_TX_IE]   = tx_ie;
    con_v[CON_RX_IE]   = rx_ie;
    con_v[CON_TX_DONE] = tx_done;
    con_v[CON_RX_RDY]  = rx_rdy;
    con_v[CON_TX_BUSY] = tx_busy;
    con_v[CON_OVR]     = overrun;
    con_v[CON_PAR_ERR] = par_err;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      rd_rxd:  rdata = {24'd0, rxd};
      rd_con:  rdata = con_v;
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: scoreboard bench for uart_periph at DIV=10 (160 clk per bit).
// Bus reads, irq/tx probes and tx frames are checked by monitors against queued values.
module tb_uart_periph;

  localparam logic [31:0] A_TXD = 32'h4000_0018;
  localparam logic [31:0] A_RXD = 32'h4000_001C;
  localparam logic [31:0] A_CON = 32'h4000_0020;
  localparam int BT = 160;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr, rx;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        irq, tx;

  uart_periph #(
    .CLK_FREQ (1_600_000),
    .BAUD     (10_000),
    .BASE_ADDR(32'h4000_0018)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rd   (rd),
    .wr   (wr),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq),
    .tx   (tx),
    .rx   (rx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] txq[$];
  logic [1:0] probe;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  function automatic int tz(input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) break;
      n++;
    end
    return n;
  endfunction

  logic [31:0] mon_act;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rd || probe != 2'd0) begin
      mon_act = rd ? rdata : (probe == 2'd1) ? {31'd0, irq} : {31'd0, tx};
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty got=%h", mon_act);
      end else begin
        mon_e = sbq.pop_front();
        check(mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  initial begin : tx_mon
    logic          prev;
    logic [NB-1:0] smp;
    logic [7:0]    eb;
    int            low;
    bit            run, ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && !tx && !reset) begin
        smp = '0;
        low = 1;
        run = 1;
        ab  = 0;
        for (int i = 1; i <= BT * (NB - 1) + BT / 2; i++) begin
          @(negedge clk);
          if (reset) begin
            ab = 1;
            break;
          end
          if (run && !tx) low++;
          else run = 0;
          if (i % BT == BT / 2) smp[i / BT] = tx;
        end
        if (!ab) begin
          if (txq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected got=%h", smp[8:1]);
          end else begin
            eb = txq.pop_front();
            check("tx_start", {31'd0, smp[0]}, 32'd0);
            check("tx_byte", {24'd0, smp[8:1]}, {24'd0, eb});
            check("tx_start_len", low, BT * (1 + tz(eb)));
`ifdef UART_PARITY_EN
            check("tx_parity", {31'd0, smp[9]}, {31'd0, ^eb});
`endif
            check("tx_stop", {31'd0, smp[NB-1]}, 32'd1);
          end
        end
      end
      prev = tx;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1;
    addr = a;
    wdata = d;
    idle(1);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] e, input string n);
    sbq.push_back('{n, e});
    rd = 1'b1;
    addr = a;
    idle(1);
    rd = 1'b0;
  endtask

  task automatic probe_chk(input logic [1:0] k, input logic e, input string n);
    sbq.push_back('{n, {31'd0, e}});
    probe = k;
    idle(1);
    probe = 2'd0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    rx = 1'b0;
    idle(BT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BT);
    end
`ifdef UART_PARITY_EN
    rx = par;
    idle(BT);
`endif
    rx = stop;
    idle(BT);
    rx = 1'b1;
    idle(20);
  endtask

  initial begin
    reset = 1'b1;
    rd = 1'b0;
    wr = 1'b0;
    rx = 1'b1;
    addr = '0;
    wdata = '0;
    probe = 2'd0;
    idle(5);
    reset = 1'b0;
    idle(2);

    bus_rd(A_CON, 32'h00, "rst_con");
    bus_rd(A_RXD, 32'h00, "rst_rxd");
    probe_chk(2'd1, 1'b0, "rst_irq");
    probe_chk(2'd2, 1'b1, "rst_tx");

    bus_wr(A_CON, 32'h1);
    txq.push_back(8'hA5);
    bus_wr(A_TXD, 32'hA5);
    idle(50);
    bus_rd(A_CON, 32'h11, "t1_busy_a");
    idle(700);
    bus_rd(A_CON, 32'h11, "t1_busy_b");
    idle(700);
    bus_rd(A_CON, 32'h11, "t1_busy_c");
    idle(200);
    probe_chk(2'd1, 1'b1, "t1_irq");
    bus_rd(A_CON, 32'h05, "t1_done");
    idle(1);
    probe_chk(2'd1, 1'b0, "t1_irq_clr");

    bus_wr(A_CON, 32'h2);
    send_frame(8'h3C, 1'b0, 1'b1);
    probe_chk(2'd1, 1'b1, "t2_irq");
    bus_rd(A_CON, 32'h0A, "t2_con");
    bus_rd(A_RXD, 32'h3C, "t2_rxd");
    idle(1);
    probe_chk(2'd1, 1'b0, "t2_irq_clr");
    bus_rd(A_CON, 32'h02, "t2_con_clr");

    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    bus_rd(A_CON, 32'h2A, "t3_ovr");
    bus_rd(A_CON, 32'h0A, "t3_ovr_clr");
    bus_rd(A_RXD, 32'h22, "t3_rxd");

    send_frame(8'h5A, 1'b1, 1'b0);
    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(400);
    bus_rd(A_CON, 32'h02, "t4_con");
    bus_rd(A_RXD, 32'h22, "t4_rxd");

    txq.push_back(8'h55);
    bus_wr(A_TXD, 32'h55);
    idle(100);
    bus_wr(A_TXD, 32'hFF);
    idle(1700);
    bus_rd(A_CON, 32'h06, "t5_done");
    bus_wr(A_TXD, 32'h33);
    idle(700);
    probe_chk(2'd2, 1'b0, "t5_mid_low");
    reset = 1'b1;
    idle(1);
    probe_chk(2'd2, 1'b1, "t5_rst_tx");
    reset = 1'b0;
    idle(2);
    bus_rd(A_CON, 32'h00, "t5_rst_con");
    bus_rd(A_RXD, 32'h00, "t5_rst_rxd");
    probe_chk(2'd1, 1'b0, "t5_rst_irq");
    idle(300);
    probe_chk(2'd2, 1'b1, "t5_tx_idle");

`ifdef UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    bus_rd(A_CON, 32'h08, "t6_ok_con");
    bus_rd(A_RXD, 32'h07, "t6_ok_rxd");
    bus_rd(A_CON, 32'h00, "t6_ok_clr");
    send_frame(8'h07, 1'b0, 1'b1);
    bus_rd(A_CON, 32'h80, "t6_perr");
    bus_rd(A_CON, 32'h00, "t6_perr_clr");
    bus_rd(A_RXD, 32'h07, "t6_rxd_kept");
`endif

    idle(50);
    check("sb_drained", sbq.size(), 32'd0);
    check("txq_drained", txq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
